uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter that drains the TX FIFO and serializes each byte onto the line: one start bit, DATA_WIDTH data bits LSB first, then stop.
- It is the reader-side consumer of the FIFO. It pops one entry per frame using the FIFO's show-ahead read data and empty flag.
- Bit timing comes from an external oversampling baud tick (i_tick). The same tick also drives the receiver.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 16, i_tick pulses per start, data or parity bit.
- SB_TICK, 16, i_tick pulses in the stop period. 16 gives 1 stop bit, 32 gives 2.

Ports:
- i_clock, input, 1, system clock (100 MHz).
- i_reset, input, 1, asynchronous, active-low reset.
- i_tick, input, 1, one-clock baud oversample strobe.
- i_fifo_empty, input, 1, FIFO empty flag.
- i_fifo_data, input, DATA_WIDTH, FIFO head data (show-ahead, valid when not empty).
- o_fifo_read, output, 1, one-clock pop strobe to the FIFO.
- o_tx, output, 1, serial line, idle high.
- o_busy, output, 1, high from the pop cycle until the frame ends.
- o_tx_done, output, 1, one-clock pulse at the end of the stop period.

Behaviour:
- Reset (i_reset=0, takes effect immediately, not on a clock edge):
  - State goes to IDLE.
  - o_tx=1, o_fifo_read=0, o_busy=0, o_tx_done=0.
  - Shift register, tick counter and bit counter are cleared.
- Registered outputs: all outputs are registered, and o_tx is driven from a flop, not from logic.
- State IDLE:
  - If i_fifo_empty=0, capture i_fifo_data into the shift register, assert o_fifo_read for exactly that cycle, clear the tick counter and go to START.
  - Otherwise hold, with o_tx=1.
  - An i_tick arriving in the pop cycle is not counted.
- State START:
  - o_tx=0.
  - Each i_tick increments the tick counter.
  - On the tick where the counter equals OVERSAMPLE-1, clear the counter, clear the bit counter and go to DATA.
- State DATA:
  - o_tx = shift register bit 0.
  - After OVERSAMPLE ticks, shift right by 1 and increment the bit counter.
  - After bit DATA_WIDTH-1, go to PARITY (macro defined) or STOP.
- State STOP:
  - o_tx=1.
  - On tick SB_TICK-1, pulse o_tx_done for one clock and return to IDLE.
- Counting rules:
  - Counters advance only on i_tick. Clocks without a tick change nothing.
  - Tick counter width is $clog2 of the larger of OVERSAMPLE and SB_TICK.
  - Bit counter width is $clog2(DATA_WIDTH).
- Back-to-back frames: if the FIFO is non-empty when IDLE is re-entered, the next pop happens on the first IDLE clock, so the gap is 1 clock. The line stays high during the gap.
- Pop rule: exactly one pop per frame. o_fifo_read is never asserted while i_fifo_empty=1 or outside IDLE.
- FIFO changes: i_fifo_data changes after the pop are ignored, because the data was captured.
- Reset mid-frame: o_tx returns high immediately. The in-flight byte is discarded, since it was already popped, and no o_tx_done pulse is produced.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA, lasting OVERSAMPLE ticks.
  - o_tx = even parity, the XOR of the byte captured at pop.
  - Frame length becomes (DATA_WIDTH+2)*OVERSAMPLE + SB_TICK ticks.
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.
  - Frame length is (DATA_WIDTH+1)*OVERSAMPLE + SB_TICK ticks.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, 3-bit);
  - the default constants DATA_WIDTH=8, OVERSAMPLE=16, SB_TICK=16, shared with the receiver and the baud generator.
- No sub-module. The baud generator and FIFO stay external, and the datapath is a single FSM with a shift register.

Test Plan (OVERSAMPLE=16, SB_TICK=16, i_tick every 4 clocks):
- Reset: hold i_reset=0 with FIFO non-empty -> o_tx=1, o_fifo_read=0, o_busy=0 throughout; no pop.
- Single byte: FIFO presents 0xA5 -> one-clock o_fifo_read; o_tx = 0 for 16 ticks, then 1,0,1,0,0,1,0,1 at 16 ticks each, then 1 for 16 ticks; o_tx_done pulses once; frame is 160 ticks.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x55 -> exactly 3 pops, 3 correct frames, 3 o_tx_done pulses; gap between frames ≤ 1 clock plus alignment to the next tick.
- Empty FIFO: i_fifo_empty=1 for 1000 clocks with ticks present -> o_tx=1, no pop, o_busy=0.
- Reset mid-frame: deassert-to-0 during data bit 3 of 0x3C -> o_tx=1 before the next clock edge; after reset release, no o_tx_done pulse and IDLE resumes.
- Parity: macro defined, byte 0x07 -> parity bit 1 after data, frame 176 ticks; macro undefined -> 160 ticks, no parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: UART constants shared by tx, rx and baud generator,
// plus the 3-bit transmitter state encoding.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_SB_TICK    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: drains the TX FIFO (show-ahead) and serializes each byte:
// start bit, DATA_WIDTH data bits LSB first, optional even parity, stop.
// Ports: i_clock, i_reset (async, active-low), i_tick (oversample strobe),
//   i_fifo_empty/i_fifo_data (FIFO head), o_fifo_read (pop strobe),
//   o_tx (serial line), o_busy (frame in flight), o_tx_done (end pulse).
// Optional: define UART_TX_PARITY_EN to insert an even parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int SB_TICK    = UART_SB_TICK
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_read,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [TW-1:0]         tick_q;
  logic [BW-1:0]         bit_q;
  logic                  tx_q;
  logic                  rd_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef UART_TX_PARITY_EN
  logic                  par_q;
`endif

  assign o_fifo_read = rd_q;
  assign o_tx        = tx_q;
  assign o_busy      = busy_q;
  assign o_tx_done   = done_q;

  // tx_q is loaded with the value of the state being entered, so the
  // line changes on the same edge as the state register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          // A tick in this cycle is deliberately ignored.
          if (!i_fifo_empty) begin
            shreg_q <= i_fifo_data;
            tick_q  <= '0;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            state_q <= START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^i_fifo_data;
`endif
          end
        end
        START: begin
          if (i_tick) begin
            if (tick_q == OS_LAST) begin
              tick_q  <= '0;
              bit_q   <= '0;
              tx_q    <= shreg_q[0];
              state_q <= DATA;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (tick_q == OS_LAST) begin
              tick_q  <= '0;
              shreg_q <= shreg_q >> 1;
              if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                tx_q    <= par_q;
                state_q <= PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= STOP;
`endif
              end else begin
                bit_q <= bit_q + BW'(1);
                tx_q  <= shreg_q[1];
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (i_tick) begin
            if (tick_q == OS_LAST) begin
              tick_q  <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (i_tick) begin
            if (tick_q == SB_LAST) begin
              tick_q  <= '0;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: begin
          tick_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a FIFO model,
// a 1-in-4 tick source and a tick-level line reference model.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int OS = 16;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = (DW + 2) * OS + SB;
`else
  localparam int FRAME = (DW + 1) * OS + SB;
`endif
  localparam int AFTER_DATA = (DW + 1) * OS;

  typedef bit bq_t[$];

  typedef struct {
    logic [7:0] data;
    bit         par;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick  = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] fdata = 8'h00;
  logic       rd;
  logic       tx;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int dones  = 0;
  int bad_pop = 0;
  int tdiv   = 0;
  bit exp_read = 1'b0;

  logic [7:0] fq[$];
  logic [7:0] popped[$];
  bq_t cur;
  bq_t last;

  uart_tx dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_tick       (tick),
    .i_fifo_empty (empty),
    .i_fifo_data  (fdata),
    .o_fifo_read  (rd),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_tx_done    (done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Line level expected on each counted tick of a frame.
  function automatic bq_t model(input logic [7:0] b);
    bq_t q;
    repeat (OS) q.push_back(1'b0);
    for (int i = 0; i < DW; i++)
      repeat (OS) q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    repeat (OS) q.push_back(^b);
`endif
    repeat (SB) q.push_back(1'b1);
    return q;
  endfunction

  // FIFO model, tick source and line monitor, all on the falling edge.
  initial begin
    bq_t exp;
    int  mism;
    forever begin
      @(negedge clk);
      if (exp_read) begin
        chk("b2b_gap_pop", int'(rd), 1);
        exp_read = 1'b0;
      end
      if (rd === 1'b1) begin
        pops++;
        if (fq.size() == 0) begin
          bad_pop++;
        end else begin
          popped.push_back(fq.pop_front());
        end
      end
      if (done === 1'b1) begin
        dones++;
        chk("gap_line_high", int'(tx), 1);
        if (popped.size() == 0) begin
          chk("done_without_pop", 1, 0);
        end else begin
          exp  = model(popped.pop_front());
          chk("frame_len", cur.size(), exp.size());
          mism = 0;
          for (int i = 0; i < exp.size() && i < cur.size(); i++)
            if (cur[i] != exp[i]) mism++;
          chk("frame_bits", mism, 0);
        end
        last = cur;
        cur.delete();
        if (fq.size() > 0) exp_read = 1'b1;
      end
      tdiv  = (tdiv + 1) % 4;
      tick  = (tdiv == 0);
      empty = (fq.size() == 0);
      fdata = (fq.size() > 0) ? fq[0] : 8'($urandom);
      if (busy === 1'b1 && tick) cur.push_back(tx);
    end
  end

  task automatic wait_dones(input int n, input int maxc,
                            input string nm);
    int k = 0;
    while (dones < n && k < maxc) begin
      @(posedge clk);
      k++;
    end
    chk(nm, int'(dones >= n), 1);
  endtask

  task automatic mid_reset(input logic [7:0] b, input int at,
                           input string nm);
    int k = 0;
    int d0 = dones;
    @(posedge clk); #1;
    fq.push_back(b);
    while (!(busy === 1'b1 && cur.size() >= at) && k < 4000) begin
      @(posedge clk);
      k++;
    end
    chk({nm, "_reach"}, int'(k < 4000), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk({nm, "_tx_high"}, int'(tx), 1);
    chk({nm, "_busy_low"}, int'(busy), 0);
    popped.delete();
    cur.delete();
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk({nm, "_no_done"}, dones, d0);
    chk({nm, "_idle_tx"}, int'(tx), 1);
    chk({nm, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    vec_t vt[7];
    int   bad;
    int   p0;
    int   d0;

    vt = '{
      '{8'h5A, 1'b0}, '{8'h00, 1'b0}, '{8'hFF, 1'b0},
      '{8'h07, 1'b1}, '{8'h80, 1'b1}, '{8'h01, 1'b1},
      '{8'hC3, 1'b0}
    };

    // Reset held with a non-empty FIFO.
    #1 rst_n = 1'b0;
    fq.push_back(8'hA5);
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        bad++;
    end
    chk("reset_hold", bad, 0);
    chk("reset_no_pop", pops, 0);

    // Single byte 0xA5.
    @(posedge clk); #2 rst_n = 1'b1;
    wait_dones(1, 2000, "single_timeout");
    chk("single_pops", pops, 1);
    chk("single_dones", dones, 1);
    chk("single_ticks", last.size(), FRAME);

    // Table of single frames with parity / stop expectation.
    foreach (vt[i]) begin
      d0 = dones;
      @(posedge clk); #1;
      fq.push_back(vt[i].data);
      wait_dones(d0 + 1, 2000, "vec_timeout");
      chk("vec_ticks", last.size(), FRAME);
`ifdef UART_TX_PARITY_EN
      chk("vec_parity",
          (last.size() > AFTER_DATA) ? int'(last[AFTER_DATA]) : -1,
          int'(vt[i].par));
`else
      chk("vec_stop_after_data",
          (last.size() > AFTER_DATA) ? int'(last[AFTER_DATA]) : -1, 1);
`endif
    end

    // Back-to-back 0x00, 0xFF, 0x55.
    p0 = pops;
    d0 = dones;
    @(posedge clk); #1;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    fq.push_back(8'h55);
    wait_dones(d0 + 3, 3000, "b2b_timeout");
    chk("b2b_pops", pops - p0, 3);
    chk("b2b_dones", dones - d0, 3);

    // Random bytes with random spacing.
    p0 = pops;
    d0 = dones;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      fq.push_back(8'($urandom));
      repeat ($urandom_range(0, 800)) @(posedge clk);
    end
    wait_dones(d0 + 6, 6000, "rand_timeout");
    chk("rand_pops", pops - p0, 6);

    // Empty FIFO with ticks running.
    p0 = pops;
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("empty_idle", bad, 0);
    chk("empty_no_pop", pops, p0);

    // Reset during data bit 3 of 0x3C, then during the start bit.
    mid_reset(8'h3C, OS * 4 + OS / 2, "midreset_bit3");
    mid_reset(8'h3C, OS / 2, "midreset_start");

    // Transmitter still works after a mid-frame reset.
    d0 = dones;
    @(posedge clk); #1;
    fq.push_back(8'h81);
    wait_dones(d0 + 1, 2000, "post_reset_timeout");
    chk("post_reset_ticks", last.size(), FRAME);

    chk("no_pop_when_empty", bad_pop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
